// File: rtl/bcd_stopwatch_if.sv
// Pin bundle for the BCD stopwatch: push-button/tick levels in, digits and status out.
// The master side drives the button and tick levels; the slave side is the stopwatch core.
interface bcd_stopwatch_if;
   logic       tick_in;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [3:0] disp_min;
   logic [3:0] disp_st;
   logic [3:0] disp_so;
   logic [3:0] disp_tn;
   logic       running;
   logic       lap_hold;
   logic       ovf;

   modport master (
      output tick_in, start_stop, clear, lap,
      input  disp_min, disp_st, disp_so, disp_tn, running, lap_hold, ovf
   );

   modport slave (
      input  tick_in, start_stop, clear, lap,
      output disp_min, disp_st, disp_so, disp_tn, running, lap_hold, ovf
   );
endinterface

// File: rtl/bcd_stopwatch.sv
// M:SS.T BCD stopwatch with IDLE/RUN/PAUSE control and synchronised button/tick inputs.
// Define STOPWATCH_LAP_EN to add the lap snapshot/freeze feature.
module bcd_stopwatch #(
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   bcd_stopwatch_if.slave  sw
);

   localparam int TICK = 0;
   localparam int SS   = 1;
   localparam int CLR  = 2;
`ifdef STOPWATCH_LAP_EN
   localparam int LAP  = 3;
   localparam int NIN  = 4;
`else
   localparam int NIN  = 3;
`endif

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   logic [NIN-1:0]                  async_in;
   logic [NIN-1:0][SYNC_STAGES-1:0] sync_q;
   logic [NIN-1:0]                  prev_q;
   logic [NIN-1:0]                  stb_q;
   logic [SYNC_STAGES:0]            settle_q;

`ifdef STOPWATCH_LAP_EN
   assign async_in = {sw.lap, sw.clear, sw.start_stop, sw.tick_in};
`else
   assign async_in = {sw.clear, sw.start_stop, sw.tick_in};
`endif

   // settle_q masks strobes until the synchronisers and edge flops reflect the
   // real input levels, so a button already held at reset release is not an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q   <= '0;
         prev_q   <= '0;
         stb_q    <= '0;
         settle_q <= '0;
      end else begin
         settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
         for (int i = 0; i < NIN; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
            prev_q[i] <= sync_q[i][SYNC_STAGES-1];
            stb_q[i]  <= sync_q[i][SYNC_STAGES-1] & ~prev_q[i] & settle_q[SYNC_STAGES];
         end
      end
   end

   logic tick_stb, ss_stb, clr_stb;
   assign tick_stb = stb_q[TICK];
   assign ss_stb   = stb_q[SS];
   assign clr_stb  = stb_q[CLR];

   state_t          state_q, state_d;
   logic            do_clear;
   logic [3:0][3:0] cnt_q, cnt_d, cnt_inc;
   logic            wrap;
   logic            count_en;
   logic            ovf_q, ovf_d;
   logic            running_q, running_d;

   always_comb begin
      state_d  = state_q;
      do_clear = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_stb)     do_clear = 1'b1;
            else if (ss_stb) state_d  = RUN;
         end
         RUN: begin
            if (ss_stb) state_d = PAUSE;
         end
         PAUSE: begin
            if (clr_stb) begin
               state_d  = IDLE;
               do_clear = 1'b1;
            end else if (ss_stb) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Digit index 0 = tenths, 1 = seconds-ones, 2 = seconds-tens, 3 = minutes.
   always_comb begin
      cnt_inc = cnt_q;
      wrap    = 1'b0;
      if (cnt_q[0] != 4'd9) cnt_inc[0] = cnt_q[0] + 4'd1;
      else begin
         cnt_inc[0] = 4'd0;
         if (cnt_q[1] != 4'd9) cnt_inc[1] = cnt_q[1] + 4'd1;
         else begin
            cnt_inc[1] = 4'd0;
            if (cnt_q[2] != 4'd5) cnt_inc[2] = cnt_q[2] + 4'd1;
            else begin
               cnt_inc[2] = 4'd0;
               if (cnt_q[3] != 4'd9) cnt_inc[3] = cnt_q[3] + 4'd1;
               else begin
                  cnt_inc[3] = 4'd0;
                  wrap       = 1'b1;
               end
            end
         end
      end
   end

   // Uses the current state, so a tick that lands with a pause request still counts.
   assign count_en  = tick_stb && (state_q == RUN);
   assign cnt_d     = do_clear ? '0 : (count_en ? cnt_inc : cnt_q);
   assign ovf_d     = count_en & wrap;
   assign running_d = (state_d == RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         running_q <= running_d;
      end
   end

   logic [3:0][3:0] disp;

`ifdef STOPWATCH_LAP_EN
   logic [3:0][3:0] snap_q, snap_d;
   logic            lap_hold_q, lap_hold_d;

   always_comb begin
      snap_d     = snap_q;
      lap_hold_d = lap_hold_q;
      if (stb_q[LAP]) begin
         if (lap_hold_q) lap_hold_d = 1'b0;
         else if (state_q == RUN) begin
            snap_d     = cnt_q;
            lap_hold_d = 1'b1;
         end
      end
      if (do_clear) lap_hold_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_q     <= '0;
         lap_hold_q <= 1'b0;
      end else begin
         snap_q     <= snap_d;
         lap_hold_q <= lap_hold_d;
      end
   end

   assign disp        = lap_hold_q ? snap_q : cnt_q;
   assign sw.lap_hold = lap_hold_q;
`else
   assign disp        = cnt_q;
   assign sw.lap_hold = 1'b0;
`endif

   assign sw.disp_tn  = disp[0];
   assign sw.disp_so  = disp[1];
   assign sw.disp_st  = disp[2];
   assign sw.disp_min = disp[3];
   assign sw.running  = running_q;
   assign sw.ovf      = ovf_q;

endmodule
